// File: rtl/cp0_reg_pkg.sv
// CP0 register file shared defines.
// Addresses, exception codes, field positions.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TR   = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam int EXL_BIT   = 1;
  localparam int BD_BIT    = 31;
  localparam int IV_BIT    = 23;
  localparam int WP_BIT    = 22;
  localparam int EXC_LSB   = 2;
  localparam int EXC_MSB   = 6;
  localparam int IPSW_LSB  = 8;
  localparam int IPSW_MSB  = 9;
  localparam int IPHW_LSB  = 10;
  localparam int IPHW_MSB  = 15;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RST = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL   = 32'h004C_0102;

  // Valid bit plus ExcCode for a non-eret exception type.
  function automatic logic [5:0] exc_decode(input logic [31:0] t);
    logic [5:0] r;
    r = 6'd0;
    case (t)
      EXC_INT: r = {1'b1, 5'd0};
      EXC_SYS: r = {1'b1, 5'd8};
      EXC_RI:  r = {1'b1, 5'd10};
      EXC_TR:  r = {1'b1, 5'd13};
      EXC_OV:  r = {1'b1, 5'd12};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer,
// Status/Cause/EPC exception state, read mux.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_timer;

  logic [5:0]  w_dec;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_eret;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_hit;

  assign w_dec  = exc_decode(excepttype_i);
  assign w_exc  = w_dec[5];
  assign w_code = w_dec[4:0];
  assign w_eret = (excepttype_i == EXC_ERET);

  assign w_wr_count  = we_i && (waddr_i == CP0_REG_COUNT);
  assign w_wr_cmp    = we_i && (waddr_i == CP0_REG_COMPARE);
  assign w_wr_status = we_i && (waddr_i == CP0_REG_STATUS);
  assign w_wr_cause  = we_i && (waddr_i == CP0_REG_CAUSE);
  assign w_wr_epc    = we_i && (waddr_i == CP0_REG_EPC);
  assign w_hit       = (r_compare != 32'd0) && (r_count == r_compare);

  // State update; exception fields are assigned last so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_status  <= STATUS_RST;
      r_cause   <= 32'd0;
      r_epc     <= 32'd0;
      r_timer   <= 1'b0;
    end else begin
      r_cause[IPHW_MSB:IPHW_LSB] <= int_i;
      if (w_wr_count) r_count <= data_i;
      else            r_count <= r_count + 32'd1;
      if (w_wr_cmp) begin
        r_compare <= data_i;
        r_timer   <= 1'b0;
      end else if (w_hit) begin
        r_timer <= 1'b1;
      end
      if (w_wr_status) r_status <= data_i;
      if (w_wr_epc)    r_epc    <= data_i;
      if (w_wr_cause) begin
        r_cause[IPSW_MSB:IPSW_LSB] <= data_i[IPSW_MSB:IPSW_LSB];
        r_cause[WP_BIT] <= data_i[WP_BIT];
        r_cause[IV_BIT] <= data_i[IV_BIT];
      end
      if (w_exc) begin
        if (!r_status[EXL_BIT]) begin
          r_epc <= is_in_delayslot_i ?
                   current_inst_addr_i - 32'd4 :
                   current_inst_addr_i;
          r_cause[BD_BIT] <= is_in_delayslot_i;
        end
        r_status[EXL_BIT] <= 1'b1;
        r_cause[EXC_MSB:EXC_LSB] <= w_code;
      end else if (w_eret) begin
        r_status[EXL_BIT] <= 1'b0;
      end
    end
  end

  // Combinational read port for EX.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = r_count;
      CP0_REG_COMPARE: data_o = r_compare;
      CP0_REG_STATUS:  data_o = r_status;
      CP0_REG_CAUSE:   data_o = r_cause;
      CP0_REG_EPC:     data_o = r_epc;
      CP0_REG_PRID:    data_o = PRID_VAL;
      CP0_REG_CONFIG:  data_o = CONFIG_RST;
      default:         data_o = 32'd0;
    endcase
  end

  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign config_o    = CONFIG_RST;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = r_timer;

endmodule
